iter_mdu: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers.
- Successor to the single-cycle combinational ALU multiply/divide paths: adds signed and unsigned iterative multiply and divide, full remainder, MTHI/MTLO, and valid/ready handshakes on both sides.
- Sits beside the ALU in the EX stage; the pipeline stalls on in_ready/out_valid.
- Provides a cancel for exception flush.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_div_step.sv | 28 ++
 rtl/iter_mdu.sv | 198 +++++++++++++++++++
 tb/tb_iter_mdu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings driven on iter_mdu.op
//   - FSM state encoding
//   - default datapath width and its MSB index
//   - small op-class helpers used by the control logic
package mdu_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_MSB   = DEF_WIDTH - 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic op_is_mul(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_i  partial remainder (always < divisor on entry)
//   bit_i  next dividend bit shifted in
//   div_i  divisor magnitude
//   rem_o  next partial remainder
//   q_o    quotient bit produced by this step
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  assign shifted = {rem_i, bit_i};
  // When the subtraction succeeds the true difference is below div_i, so
  // it fits in WIDTH bits and the modular low-half subtraction is exact.
  assign trial   = shifted[WIDTH-1:0] - div_i;
  assign q_o     = (shifted >= {1'b0, div_i});
  assign rem_o   = q_o ? trial : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a
// one-cycle sign fix-up. Results are held in DONE until out_ready commits them.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   request handshake (in_ready only while idle)
//   op, a, b              operation and operands
//   cancel                flush any in-flight operation without commit
//   out_valid / out_ready result handshake (commit on both high)
//   hi, lo                committed HI/LO
//   div_by_zero           last committed op was a divide by zero
// Build option: MDU_EARLY_EXIT_EN lets a multiply leave CALC as soon as the
// remaining multiplier bits are zero.
module iter_mdu
  import mdu_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // original a: MT source / div-by-zero HI
  logic [WIDTH-1:0]   b_q, b_d;          // multiplier (shifts) or divisor (static)
  logic [2*WIDTH-1:0] mcand_q, mcand_d;  // multiplicand, shifted left per bit
  logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i (acc_q[MSB]),
    .div_i (b_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign mag_a = (op_is_signed(op) && a[MSB]) ? -a : a;
  assign mag_b = (op_is_signed(op) && b[MSB]) ? -b : b;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bz_d      = bz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !cancel) begin
          op_d      = op;
          a_d       = a;
          b_d       = mag_b;
          cnt_d     = '0;
          neg_res_d = op_is_signed(op) && (a[MSB] ^ b[MSB]);
          neg_rem_d = op_is_signed(op) && a[MSB];
          bz_d      = op_is_div(op) && (b == '0);
          mcand_d   = (2*WIDTH)'(mag_a);
          // Multiply accumulates from zero; divide seeds the low half
          // with the dividend that gets shifted into the remainder.
          acc_d     = op_is_div(op) ? (2*WIDTH)'(mag_a) : '0;
          state_d   = (op_is_mul(op) || op_is_div(op)) ? ST_CALC : ST_DONE;
        end
      end

      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_is_mul(op_q)) begin
            // Partial products are added in place, so the accumulator is
            // already final whenever the remaining multiplier bits are zero.
            acc_d   = acc_q + (b_q[0] ? mcand_q : '0);
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
          end else begin
            acc_d = {step_rem, acc_q[MSB-1:0], step_q};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end
`ifdef MDU_EARLY_EXIT_EN
          if (op_is_mul(op_q) && (b_q[MSB:1] == '0)) begin
            state_d = ST_FIX;
          end
`endif
        end
      end

      ST_FIX: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (op_is_mul(op_q)) begin
            if (neg_res_q) acc_d = -acc_q;
          end else if (bz_q) begin
            acc_d = {a_q, {WIDTH{1'b1}}};
          end else begin
            acc_d[MSB:0] = neg_res_q ? -acc_q[MSB:0] : acc_q[MSB:0];
            acc_d[2*WIDTH-1:WIDTH] = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                                               : acc_q[2*WIDTH-1:WIDTH];
          end
        end
      end

      ST_DONE: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
          dbz_d   = bz_q;
          if (op_is_mul(op_q) || op_is_div(op_q)) begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[MSB:0];
          end else if (op_q == OP_MTHI) begin
            hi_d = a_q;
          end else if (op_q == OP_MTLO) begin
            lo_d = a_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bz_q      <= bz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_mdu.sv
// Directed-vector bench for iter_mdu (WIDTH = 32). Edge counts treat the
// accepting edge as edge 1.
module tb_iter_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] hi, lo;
  logic        div_by_zero;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  iter_mdu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .cancel      (cancel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (DUT idle) and wait, bounded, for out_valid.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int unsigned edges);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  // Full request with out_ready high: check latency, then the committed state.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int unsigned exp_edges,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    int unsigned e;
    run_op(o, x, y, e);
    check_eq({tag, "_lat"}, 64'(e), 64'(exp_edges));
    tick();
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  initial begin
    int unsigned e;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    tick();

    do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op("mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    do_op("mult_m3xm5", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 34, 32'h0, 32'd15, 1'b0);
    do_op("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("div_7dm2", 3'b010, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
    do_op("div_m7dm2", 3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFF, 32'd3, 1'b0);
    do_op("divu_100d7", 3'b011, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
    do_op("divu_by0", 3'b011, 32'd100, 32'd0, 34, 32'd100, 32'hFFFF_FFFF, 1'b1);
    do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0);
    do_op("mthi_7", 3'b100, 32'd7, 32'd0, 1, 32'd7, 32'h8000_0000, 1'b0);

    // MTHI held in DONE by a stalled consumer.
    out_ready = 1'b0;
    run_op(3'b100, 32'h1234, 32'd0, e);
    check_eq("mthi_hold_lat", 64'(e), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mthi_hold_valid", 64'(out_valid), 64'd1);
      check_eq("mthi_hold_hi", 64'(hi), 64'd7);
    end
    out_ready = 1'b1;
    tick();
    check_eq("mthi_commit_hi", 64'(hi), 64'h1234);
    check_eq("mthi_commit_ready", 64'(in_ready), 64'd1);

    do_op("mtlo_55", 3'b101, 32'h55, 32'd0, 1, 32'h1234, 32'h55, 1'b0);

    // Cancel in CALC at edge 10.
    op = 3'b001; a = 32'd5; b = 32'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 2; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("cancel_calc_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check_eq("cancel_calc_novalid", 64'(seen), 64'd0);
    check_eq("cancel_calc_hi", 64'(hi), 64'h1234);
    check_eq("cancel_calc_lo", 64'(lo), 64'h55);

    // Cancel beats out_ready in DONE.
    out_ready = 1'b0;
    run_op(3'b100, 32'h99, 32'd0, e);
    cancel = 1'b1; out_ready = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("cancel_done_hi", 64'(hi), 64'h1234);
    check_eq("cancel_done_ready", 64'(in_ready), 64'd1);

    // Cancel in IDLE blocks acceptance.
    op = 3'b001; a = 32'd3; b = 32'd3; in_valid = 1'b1; cancel = 1'b1;
    tick();
    in_valid = 1'b0; cancel = 1'b0;
    check_eq("cancel_idle_ready", 64'(in_ready), 64'd1);
    check_eq("cancel_idle_valid", 64'(out_valid), 64'd0);

`ifdef MDU_EARLY_EXIT_EN
    run_op(3'b001, 32'd9, 32'd1, e);
    check_eq("early_lat_le3", 64'(e <= 3), 64'd1);
    tick();
`else
    do_op("multu_b1", 3'b001, 32'd9, 32'd1, 34, 32'd0, 32'd9, 1'b0);
`endif
    check_eq("multu_b1_lo", 64'(lo), 64'd9);

    // Asynchronous reset mid-operation.
    op = 3'b000; a = 32'd11; b = 32'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
